// File: rtl/pcie_ltssm_pkg.sv
// Shared LTSSM definitions: substate codes, ordered-set symbol constants and the
// per-substate transmit exit table used by the transmit half of the LTSSM.
package pcie_ltssm_pkg;

    typedef enum logic [3:0] {
        DETECT_QUIET     = 4'd0,
        DETECT_ACTIVE    = 4'd1,
        POLLING_ACTIVE   = 4'd2,
        POLLING_CONFIG   = 4'd3,
        CONFIG_LW_START  = 4'd4,
        CONFIG_LW_ACCEPT = 4'd5,
        CONFIG_LN_WAIT   = 4'd6,
        CONFIG_LN_ACCEPT = 4'd7,
        CONFIG_COMPLETE  = 4'd8,
        CONFIG_IDLE      = 4'd9,
        L0               = 4'd10
    } substate_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_DONE = 2'd2,
        ST_HOLD = 2'd3
    } tx_state_e;

    typedef enum logic [1:0] {
        OS_NONE = 2'd0,
        OS_TS1  = 2'd1,
        OS_TS2  = 2'd2,
        OS_IDLE = 2'd3
    } os_kind_e;

    typedef struct packed {
        os_kind_e    kind;
        logic [10:0] min_cnt;
        logic [4:0]  post_req;
    } sub_cfg_t;

    localparam logic [7:0]  COM           = 8'hBC;
    localparam logic [7:0]  PAD           = 8'hF7;
    localparam logic [7:0]  TS1_ID        = 8'h4A;
    localparam logic [7:0]  TS2_ID        = 8'h45;
    localparam logic [7:0]  GEN3_TS1_SYNC = 8'h1E;
    localparam logic [7:0]  GEN3_TS2_SYNC = 8'h2D;
    localparam logic [10:0] SENT_MAX      = 11'd2047;
    localparam logic [4:0]  POST_MAX      = 5'd31;

    function automatic os_kind_e sub_kind(input substate_e sub);
        os_kind_e k;
        case (sub)
            POLLING_ACTIVE, CONFIG_LW_START, CONFIG_LW_ACCEPT,
            CONFIG_LN_WAIT, CONFIG_LN_ACCEPT: k = OS_TS1;
            POLLING_CONFIG, CONFIG_COMPLETE:  k = OS_TS2;
            CONFIG_IDLE:                      k = OS_IDLE;
            default:                          k = OS_NONE;
        endcase
        return k;
    endfunction

    function automatic sub_cfg_t sub_cfg(input substate_e sub);
        sub_cfg_t c;
        c.kind = sub_kind(sub);
        case (sub)
            POLLING_ACTIVE: begin
                c.min_cnt  = 11'd1024;
                c.post_req = 5'd0;
            end
            POLLING_CONFIG, CONFIG_COMPLETE, CONFIG_IDLE: begin
                c.min_cnt  = 11'd0;
                c.post_req = 5'd16;
            end
            default: begin
                c.min_cnt  = 11'd0;
                c.post_req = 5'd0;
            end
        endcase
        return c;
    endfunction

endpackage

// File: rtl/tx_os_builder.sv
// One-lane 128-bit ordered-set formatter (TS1/TS2/idle), symbol 0 in the low byte.
module tx_os_builder
    import pcie_ltssm_pkg::*;
#(
    parameter int LANE       = 0,
    parameter int DEVICETYPE = 0
) (
    input  substate_e    sub,
    input  logic [2:0]   gen,
    input  logic         lane_active,
    input  logic [7:0]   link_number,
    input  logic         link_number_valid,
    input  logic [7:0]   rate_id,
    input  logic [7:0]   nfts,
    output logic [127:0] os
);
    localparam logic [7:0] LANE_ID  = 8'(LANE);
    localparam bit         UPSTREAM = (DEVICETYPE != 0);

    os_kind_e kind_s;
    logic     ts2_s, polling_s, numbered_s;

    // Symbol fields for the selected set; inactive lanes and idle sets stay all-zero.
    always_comb begin
        kind_s     = sub_kind(sub);
        ts2_s      = (kind_s == OS_TS2);
        polling_s  = (sub == POLLING_ACTIVE) || (sub == POLLING_CONFIG);
        numbered_s = (sub == CONFIG_LN_WAIT) || (sub == CONFIG_LN_ACCEPT) ||
                     (sub == CONFIG_COMPLETE) || (sub == CONFIG_IDLE);
        os = '0;
        if (lane_active && ((kind_s == OS_TS1) || ts2_s)) begin
            if (gen < 3'd3) begin
                os[7:0] = COM;
            end else begin
                os[7:0] = ts2_s ? GEN3_TS2_SYNC : GEN3_TS1_SYNC;
            end
            os[15:8]  = (polling_s || !link_number_valid) ? PAD : link_number;
            // An upstream port never owns lane numbers while widths are still being negotiated.
            os[23:16] = (polling_s || !numbered_s || ((sub == CONFIG_LW_START) && UPSTREAM))
                        ? PAD : LANE_ID;
            os[31:24] = nfts;
            os[39:32] = rate_id;
            os[47:40] = 8'h00;
            for (int s = 6; s < 16; s++) begin
                os[s*8 +: 8] = ts2_s ? TS2_ID : TS1_ID;
            end
        end else begin
            os = '0;
        end
    end

endmodule

// File: rtl/tx_ltssm.sv
// Transmit half of the LTSSM: sequences ordered sets per substate, counts accepted
// transfers and pulses finish once the substate's transmit exit condition holds.
module tx_ltssm
    import pcie_ltssm_pkg::*;
#(
    parameter int         DEVICETYPE = 0,
    parameter int         MAXLANES   = 16,
    parameter logic [7:0] NFTS       = 8'd255
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [2:0]              Gen,
    input  substate_e               substate,
    input  logic                    start,
    input  logic                    rxDone,
    input  logic [7:0]              linkNumber,
    input  logic                    linkNumberValid,
    input  logic [7:0]              rateId,
    input  logic [4:0]              numberOfDetectedLanes,
    output logic [MAXLANES*128-1:0] osOut,
    output logic                    osValid,
    input  logic                    osReady,
    output logic                    finish
);
    tx_state_e               state_q, state_d;
    substate_e               sub_q, sub_d;
    logic [10:0]             sent_q, sent_d;
    logic [4:0]              post_q, post_d;
    logic                    rx_seen_q, rx_seen_d;
    logic                    valid_q, valid_d;
    logic                    finish_q, finish_d;
    logic [MAXLANES*128-1:0] os_q, os_d, built_s;
    sub_cfg_t                cfg_s;
    logic                    xfer_s, exit_s, sends_s;

    for (genvar i = 0; i < MAXLANES; i++) begin : g_lane
        tx_os_builder #(
            .LANE       (i),
            .DEVICETYPE (DEVICETYPE)
        ) u_os (
            .sub               (sub_d),
            .gen               (Gen),
            .lane_active       (5'(i) < numberOfDetectedLanes),
            .link_number       (linkNumber),
            .link_number_valid (linkNumberValid),
            .rate_id           (rateId),
            .nfts              (NFTS),
            .os                (built_s[i*128 +: 128])
        );
    end

    // Counters; a transfer coinciding with start belongs to the abandoned sequence.
    always_comb begin
        xfer_s = valid_q & osReady;
        if (start) begin
            sub_d     = substate;
            sent_d    = 11'd0;
            post_d    = 5'd0;
            rx_seen_d = 1'b0;
        end else begin
            sub_d     = sub_q;
            sent_d    = (xfer_s && (sent_q != SENT_MAX)) ? sent_q + 11'd1 : sent_q;
            post_d    = (xfer_s && rx_seen_q && (post_q != POST_MAX)) ? post_q + 5'd1 : post_q;
            rx_seen_d = rx_seen_q | ((state_q == ST_SEND) & rxDone);
        end
        cfg_s   = sub_cfg(sub_d);
        sends_s = (cfg_s.kind != OS_NONE);
        exit_s  = sends_s && (sent_d >= cfg_s.min_cnt) && rx_seen_d && (post_d >= cfg_s.post_req);
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        if (start) begin
            state_d = ((substate == DETECT_QUIET) || (substate == DETECT_ACTIVE)) ? ST_IDLE : ST_SEND;
        end else begin
            case (state_q)
                ST_IDLE: state_d = ST_IDLE;
                ST_SEND: state_d = exit_s ? ST_DONE : ST_SEND;
                ST_DONE: state_d = ST_HOLD;
                ST_HOLD: state_d = ST_HOLD;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Output logic; the set only reloads on start or when the framer takes the current one.
    always_comb begin
        valid_d  = (state_d != ST_IDLE) && sends_s;
        finish_d = (state_d == ST_DONE);
        if (start || xfer_s) begin
            os_d = valid_d ? built_s : '0;
        end else begin
            os_d = os_q;
        end
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Counter and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sub_q     <= DETECT_QUIET;
            sent_q    <= 11'd0;
            post_q    <= 5'd0;
            rx_seen_q <= 1'b0;
            valid_q   <= 1'b0;
            finish_q  <= 1'b0;
            os_q      <= '0;
        end else begin
            sub_q     <= sub_d;
            sent_q    <= sent_d;
            post_q    <= post_d;
            rx_seen_q <= rx_seen_d;
            valid_q   <= valid_d;
            finish_q  <= finish_d;
            os_q      <= os_d;
        end
    end

    assign osOut   = os_q;
    assign osValid = valid_q;
    assign finish  = finish_q;

endmodule

// File: tb/tb_tx_ltssm.sv
// Randomised bench for tx_ltssm against a behavioural model of the transmit rules.
module tb_tx_ltssm;
    import pcie_ltssm_pkg::*;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [2:0]    Gen = 3'd1;
    substate_e     substate = DETECT_QUIET;
    logic          start = 1'b0;
    logic          rxDone = 1'b0;
    logic [7:0]    linkNumber = 8'h00;
    logic          linkNumberValid = 1'b0;
    logic [7:0]    rateId = 8'h02;
    logic [4:0]    numberOfDetectedLanes = 5'd16;
    logic [2047:0] osOut;
    logic          osValid;
    logic          osReady = 1'b0;
    logic          finish;

    int checks = 0;
    int fails  = 0;

    // behavioural model
    bit            m_valid = 1'b0, m_fin = 1'b0, m_active = 1'b0, m_done = 1'b0, m_seen = 1'b0;
    int            m_cnt = 0, m_post = 0;
    substate_e     m_sub = DETECT_QUIET;
    logic [2047:0] m_os = '0;

    substate_e subs_tab [11] = '{DETECT_QUIET, DETECT_ACTIVE, POLLING_ACTIVE, POLLING_CONFIG,
                                 CONFIG_LW_START, CONFIG_LW_ACCEPT, CONFIG_LN_WAIT,
                                 CONFIG_LN_ACCEPT, CONFIG_COMPLETE, CONFIG_IDLE, L0};

    tx_ltssm dut (
        .clk                   (clk),
        .reset                 (reset),
        .Gen                   (Gen),
        .substate              (substate),
        .start                 (start),
        .rxDone                (rxDone),
        .linkNumber            (linkNumber),
        .linkNumberValid       (linkNumberValid),
        .rateId                (rateId),
        .numberOfDetectedLanes (numberOfDetectedLanes),
        .osOut                 (osOut),
        .osValid               (osValid),
        .osReady               (osReady),
        .finish                (finish)
    );

    always #5 clk = ~clk;

    function automatic bit is_ts1(substate_e s);
        return s inside {POLLING_ACTIVE, CONFIG_LW_START, CONFIG_LW_ACCEPT, CONFIG_LN_WAIT, CONFIG_LN_ACCEPT};
    endfunction

    function automatic bit is_ts2(substate_e s);
        return s inside {POLLING_CONFIG, CONFIG_COMPLETE};
    endfunction

    function automatic bit transmits(substate_e s);
        return is_ts1(s) || is_ts2(s) || (s == CONFIG_IDLE);
    endfunction

    function automatic int min_for(substate_e s);
        return (s == POLLING_ACTIVE) ? 1024 : 0;
    endfunction

    function automatic int post_for(substate_e s);
        return (s inside {POLLING_CONFIG, CONFIG_COMPLETE, CONFIG_IDLE}) ? 16 : 0;
    endfunction

    function automatic logic [2047:0] build_os(substate_e s, logic [2:0] g, logic [4:0] nl,
                                               logic [7:0] ln, logic lv, logic [7:0] rid);
        logic [2047:0] o;
        logic [7:0]    b;
        bit            ts2, polling, numbered;
        o        = '0;
        ts2      = is_ts2(s);
        polling  = (s == POLLING_ACTIVE) || (s == POLLING_CONFIG);
        numbered = s inside {CONFIG_LN_WAIT, CONFIG_LN_ACCEPT, CONFIG_COMPLETE};
        if (!(is_ts1(s) || ts2)) return o;
        for (int l = 0; l < 16; l++) begin
            if (l < int'(nl)) begin
                for (int y = 0; y < 16; y++) begin
                    case (y)
                        0:       b = (g >= 3'd3) ? (ts2 ? 8'h2D : 8'h1E) : 8'hBC;
                        1:       b = (polling || !lv) ? 8'hF7 : ln;
                        2:       b = numbered ? 8'(l) : 8'hF7;
                        3:       b = 8'hFF;
                        4:       b = rid;
                        5:       b = 8'h00;
                        default: b = ts2 ? 8'h45 : 8'h4A;
                    endcase
                    o[l*128 + y*8 +: 8] = b;
                end
            end
        end
        return o;
    endfunction

    task automatic model_step();
        bit xf;
        if (reset) begin
            m_valid = 1'b0; m_fin = 1'b0; m_active = 1'b0; m_done = 1'b0; m_seen = 1'b0;
            m_cnt = 0; m_post = 0; m_sub = DETECT_QUIET; m_os = '0;
            return;
        end
        m_fin = 1'b0;
        if (start) begin
            m_sub = substate; m_cnt = 0; m_post = 0; m_seen = 1'b0; m_done = 1'b0;
            m_active = !(substate inside {DETECT_QUIET, DETECT_ACTIVE});
            m_valid  = m_active && transmits(substate);
            m_os     = m_valid ? build_os(substate, Gen, numberOfDetectedLanes, linkNumber,
                                          linkNumberValid, rateId) : '0;
        end else begin
            xf = m_valid && osReady;
            if (m_active && !m_done) begin
                if (xf) begin
                    m_cnt++;
                    if (m_seen) m_post++;
                end
                if (rxDone) m_seen = 1'b1;
                if (transmits(m_sub) && m_cnt >= min_for(m_sub) && m_seen && m_post >= post_for(m_sub)) begin
                    m_fin  = 1'b1;
                    m_done = 1'b1;
                end
            end
            if (xf) m_os = build_os(m_sub, Gen, numberOfDetectedLanes, linkNumber, linkNumberValid, rateId);
        end
    endtask

    initial forever begin
        @(posedge clk or posedge reset);
        model_step();
    end

    // compare process
    initial forever begin
        @(negedge clk);
        checks++;
        if (osValid !== m_valid) begin
            fails++;
            $display("FAIL osValid at %0t actual=%0b expected=%0b", $time, osValid, m_valid);
        end
        checks++;
        if (finish !== m_fin) begin
            fails++;
            $display("FAIL finish at %0t actual=%0b expected=%0b", $time, finish, m_fin);
        end
        checks++;
        if (osOut !== m_os) begin
            fails++;
            for (int l = 0; l < 16; l++) begin
                if (osOut[l*128 +: 128] !== m_os[l*128 +: 128]) begin
                    $display("FAIL osOut lane %0d at %0t actual=%032h expected=%032h",
                             l, $time, osOut[l*128 +: 128], m_os[l*128 +: 128]);
                    break;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic do_start(input substate_e s, input logic [2:0] g, input logic [4:0] nl,
                            input logic [7:0] ln, input logic lv);
        @(negedge clk);
        substate = s; Gen = g; numberOfDetectedLanes = nl; linkNumber = ln; linkNumberValid = lv;
        rateId = 8'h02; start = 1'b1; osReady = 1'b0; rxDone = 1'b0;
        @(negedge clk);
        start = 1'b0;
    endtask

    // n counts transfers observed at the DUT boundary since the preceding start
    task automatic run(input int max_cyc, input int rx_at, input int rdy_pct, input int stop_at,
                       output int n, output bit fin);
        bit rx_given;
        n = 0; fin = 1'b0; rx_given = 1'b0;
        for (int c = 0; c < max_cyc; c++) begin
            @(negedge clk);
            if (finish) begin
                fin = 1'b1;
                break;
            end
            if (stop_at > 0 && n == stop_at) break;
            rxDone = (!rx_given && rx_at >= 0 && n >= rx_at);
            if (rxDone) rx_given = 1'b1;
            osReady = ($urandom_range(99) < rdy_pct);
            if (osValid && osReady) n++;
        end
        rxDone = 1'b0; osReady = 1'b0;
    endtask

    initial begin
        int n;
        bit fin;
        repeat (3) @(negedge clk);
        chk("reset_osValid", osValid, 0);
        chk("reset_finish", finish, 0);
        chk("reset_osOut_zero", (osOut == '0), 1);
        reset = 1'b0;

        do_start(POLLING_ACTIVE, 3'd1, 5'd16, 8'h00, 1'b0);
        chk("pa_sym0_com", osOut[7:0], 8'hBC);
        chk("pa_sym1_pad", osOut[15:8], 8'hF7);
        run(1500, 10, 100, 0, n, fin);
        chk("pa_finish_seen", fin, 1);
        chk("pa_transfers_at_finish", n, 1024);

        do_start(POLLING_CONFIG, 3'd1, 5'd16, 8'h00, 1'b0);
        chk("pc_sym6_ts2", osOut[55:48], 8'h45);
        run(200, 5, 100, 0, n, fin);
        chk("pc_finish_seen", fin, 1);
        chk("pc_transfers_at_finish", n, 22);

        do_start(CONFIG_LN_ACCEPT, 3'd1, 5'd4, 8'h03, 1'b1);
        chk("lna_lane2_sym1", osOut[2*128+8 +: 8], 8'h03);
        chk("lna_lane2_sym2", osOut[2*128+16 +: 8], 8'h02);
        chk("lna_lanes4_15_zero", (osOut[2047:512] == '0), 1);
        run(50, 0, 100, 0, n, fin);
        chk("lna_finish_seen", fin, 1);

        do_start(POLLING_ACTIVE, 3'd2, 5'd8, 8'h00, 1'b0);
        run(2000, -1, 60, 500, n, fin);
        chk("pa_restart_reached_500", n, 500);
        do_start(POLLING_ACTIVE, 3'd2, 5'd8, 8'h00, 1'b0);
        run(4000, 3, 60, 0, n, fin);
        chk("pa_restart_finish_seen", fin, 1);
        chk("pa_restart_transfers", n, 1024);

        do_start(POLLING_ACTIVE, 3'd1, 5'd16, 8'h00, 1'b0);
        run(100, -1, 50, 20, n, fin);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("midsend_reset_osValid", osValid, 0);
        chk("midsend_reset_osOut", (osOut == '0), 1);
        chk("midsend_reset_finish", finish, 0);
        reset = 1'b0;

        do_start(CONFIG_COMPLETE, 3'd3, 5'd2, 8'h07, 1'b1);
        chk("gen3_cc_sym0", osOut[7:0], 8'h2D);
        do_start(CONFIG_LW_START, 3'd1, 5'd4, 8'h07, 1'b1);
        chk("lws_sym2_pad", osOut[23:16], 8'hF7);
        do_start(L0, 3'd1, 5'd4, 8'h07, 1'b1);
        chk("l0_osValid", osValid, 0);

        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            start = ($urandom_range(99) < 8);
            if (start) begin
                substate              = subs_tab[$urandom_range(10)];
                Gen                   = 3'($urandom_range(5, 1));
                numberOfDetectedLanes = 5'($urandom_range(16, 1));
            end
            linkNumber      = 8'($urandom);
            linkNumberValid = 1'($urandom_range(1));
            rateId          = 8'($urandom);
            rxDone          = ($urandom_range(99) < 10);
            osReady         = ($urandom_range(99) < 70);
        end
        @(negedge clk);
        start = 1'b0; rxDone = 1'b0; osReady = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
